// File: rtl/map_tile_server_pkg.sv
// Shared definitions for the map tile server: tile codes, map geometry defaults,
// movement codes, FSM state encodings and the tile layout used to build the ROM.
package map_tile_server_pkg;

    typedef logic [2:0] tile_t;

    localparam tile_t MAP_ROAD0  = 3'b000;
    localparam tile_t MAP_ROAD1  = 3'b001;
    localparam tile_t MAP_WALL   = 3'b010;
    localparam tile_t MAP_STAIRS = 3'b011;

    localparam int SPRITE_LEN   = 32;
    localparam int MAP_ROWS_DEF = 480 / SPRITE_LEN;
    localparam int MAP_COLS_DEF = 640 / SPRITE_LEN;

    localparam logic [2:0] MOVE_NONE  = 3'd0;
    localparam logic [2:0] MOVE_UP    = 3'd1;
    localparam logic [2:0] MOVE_DOWN  = 3'd2;
    localparam logic [2:0] MOVE_LEFT  = 3'd3;
    localparam logic [2:0] MOVE_RIGHT = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Border walls, stairs near the bottom-right corner, a map-dependent wall
    // segment in the middle column, and a checkerboard of the two road tiles.
    function automatic tile_t tile_at(input int m, input int r, input int c,
                                      input int rows, input int cols);
        if (r == 0 || r == rows - 1 || c == 0 || c == cols - 1)
            return MAP_WALL;
        if (r == rows - 2 && c == cols - 2)
            return MAP_STAIRS;
        if (c == cols / 2 && r >= 2 && r <= 4 + 2 * m)
            return MAP_WALL;
        if (((r + c + m) % 2) == 0)
            return MAP_ROAD1;
        return MAP_ROAD0;
    endfunction

endpackage

// File: rtl/map_tile_rom.sv
// Synchronous single-port tile ROM holding all maps back to back, one-cycle read.
module map_tile_rom
    import map_tile_server_pkg::*;
#(
    parameter int NUM_MAPS = 4,
    parameter int MAP_ROWS = MAP_ROWS_DEF,
    parameter int MAP_COLS = MAP_COLS_DEF,
    parameter int ADDR_W   = $clog2(NUM_MAPS * MAP_ROWS * MAP_COLS)
) (
    input  logic              clk_13,
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        data
);

    localparam int MAP_SIZE = MAP_ROWS * MAP_COLS;
    localparam int DEPTH    = NUM_MAPS * MAP_SIZE;
    localparam int TBL_LEN  = 1 << ADDR_W;

    tile_t rom_table [TBL_LEN];
    tile_t data_reg;

    // Addresses past the last map read as wall rather than leaving holes.
    generate
        for (genvar gi = 0; gi < TBL_LEN; gi++) begin : g_tile
            if (gi < DEPTH) begin : g_map
                assign rom_table[gi] = tile_at(gi / MAP_SIZE, (gi % MAP_SIZE) / MAP_COLS,
                                               gi % MAP_COLS, MAP_ROWS, MAP_COLS);
            end else begin : g_pad
                assign rom_table[gi] = MAP_WALL;
            end
        end
    endgenerate

    always_ff @(posedge clk_13) begin
        data_reg <= rom_table[addr];
    end

    assign data = data_reg;

endmodule

// File: rtl/map_tile_server.sv
// Round-robin tile lookup server shared by the player and monsters.
// Optional MAP_OOB_CHECK_EN: out-of-range queries answer MAP_WALL instead of ROM data.
module map_tile_server
    import map_tile_server_pkg::*;
#(
    parameter int NUM_REQ  = 5,
    parameter int MAP_ROWS = MAP_ROWS_DEF,
    parameter int MAP_COLS = MAP_COLS_DEF,
    parameter int NUM_MAPS = 4
) (
    input  logic                  clk_13,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*10-1:0] req_r,
    input  logic [NUM_REQ*10-1:0] req_c,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [2:0]            resp_type,
    input  logic                  level_advance,
    output logic [2:0]            map_idx,
    output logic                  busy
);

    localparam int ADDR_W = $clog2(NUM_MAPS * MAP_ROWS * MAP_COLS);
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [2:0]    MAP_LAST  = 3'(NUM_MAPS - 1);

    logic [1:0]        state_reg, state_next;
    logic [GW-1:0]     grant_reg, last_grant_reg, grant_next, cand;
    logic              grant_found;
    logic [9:0]        sel_r, sel_c;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [2:0]        map_idx_reg, map_idx_inc;
    logic              pending_reg;
    logic [2:0]        rom_data;
`ifdef MAP_OOB_CHECK_EN
    logic              oob_reg, oob_next;
`endif

    // Search begins just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_next  = last_grant_reg;
        cand        = last_grant_reg;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(last_grant_reg) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_next  = cand;
            end
        end
    end

    always_comb begin
        sel_r = '0;
        sel_c = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_next == GW'(k)) begin
                sel_r = req_r[k*10 +: 10];
                sel_c = req_c[k*10 +: 10];
            end
        end
        addr_next = ADDR_W'(int'(map_idx_reg) * (MAP_ROWS * MAP_COLS)
                            + int'(sel_r) * MAP_COLS + int'(sel_c));
`ifdef MAP_OOB_CHECK_EN
        oob_next = (sel_r >= 10'(MAP_ROWS)) || (sel_c >= 10'(MAP_COLS));
`endif
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE: state_next = grant_found ? ST_READ : ST_IDLE;
            ST_READ: state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign map_idx_inc = (map_idx_reg == MAP_LAST) ? map_idx_reg : map_idx_reg + 3'd1;

    always_ff @(posedge clk_13 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_INIT;
            addr_reg       <= '0;
            map_idx_reg    <= '0;
            pending_reg    <= 1'b0;
`ifdef MAP_OOB_CHECK_EN
            oob_reg        <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        grant_reg      <= grant_next;
                        last_grant_reg <= grant_next;
                        addr_reg       <= addr_next;
`ifdef MAP_OOB_CHECK_EN
                        oob_reg        <= oob_next;
`endif
                    end
                    // The address above already captured the old map index.
                    if (level_advance) begin
                        map_idx_reg    <= map_idx_inc;
                        last_grant_reg <= LAST_INIT;
                    end
                end
                ST_READ: begin
                    if (level_advance)
                        pending_reg <= 1'b1;
                end
                ST_RESP: begin
                    if (pending_reg || level_advance) begin
                        map_idx_reg    <= map_idx_inc;
                        last_grant_reg <= LAST_INIT;
                    end
                    pending_reg <= 1'b0;
                end
                default: pending_reg <= 1'b0;
            endcase
        end
    end

    map_tile_rom #(
        .NUM_MAPS (NUM_MAPS),
        .MAP_ROWS (MAP_ROWS),
        .MAP_COLS (MAP_COLS),
        .ADDR_W   (ADDR_W)
    ) u_rom (
        .clk_13 (clk_13),
        .addr   (addr_reg),
        .data   (rom_data)
    );

    always_comb begin
        resp_valid = '0;
        resp_type  = MAP_WALL;
        if (state_reg == ST_RESP) begin
            resp_valid = NUM_REQ'(1) << grant_reg;
`ifdef MAP_OOB_CHECK_EN
            resp_type  = oob_reg ? MAP_WALL : rom_data;
`else
            resp_type  = rom_data;
`endif
        end
    end

    assign map_idx = map_idx_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_map_tile_server.sv
// Directed bench for map_tile_server; out-of-range cases run only with MAP_OOB_CHECK_EN.
module tb_map_tile_server;
    import map_tile_server_pkg::*;

    localparam int NR = 5;

    logic            clk_13 = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*10-1:0] req_r = '0;
    logic [NR*10-1:0] req_c = '0;
    logic [NR-1:0]   resp_valid;
    logic [2:0]      resp_type;
    logic            level_advance = 1'b0;
    logic [2:0]      map_idx;
    logic            busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_13 = ~clk_13;

    map_tile_server dut (
        .clk_13        (clk_13),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_r         (req_r),
        .req_c         (req_c),
        .resp_valid    (resp_valid),
        .resp_type     (resp_type),
        .level_advance (level_advance),
        .map_idx       (map_idx),
        .busy          (busy)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_13);
        #1;
    endtask

    task automatic set_rc(input int k, input int r, input int c);
        req_r[k*10 +: 10] = 10'(r);
        req_c[k*10 +: 10] = 10'(c);
    endtask

    // Single requester: grant this cycle, READ next, RESP the one after.
    task automatic query(input string tag, input int k, input int r, input int c,
                         input logic [2:0] exp_type);
        set_rc(k, r, c);
        req_valid = NR'(1) << k;
        tick();
        check_vec({tag, "_read_valid"}, 32'(resp_valid), 0);
        check_vec({tag, "_read_busy"}, 32'(busy), 1);
        tick();
        check_vec({tag, "_valid"}, 32'(resp_valid), 32'(1) << k);
        check_vec({tag, "_type"}, 32'(resp_type), 32'(exp_type));
        req_valid = '0;
        tick();
        check_vec({tag, "_done_valid"}, 32'(resp_valid), 0);
        check_vec({tag, "_done_type"}, 32'(resp_type), 32'(MAP_WALL));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check_vec("rst_busy", 32'(busy), 0);
        check_vec("rst_valid", 32'(resp_valid), 0);
        check_vec("rst_type", 32'(resp_type), 32'(MAP_WALL));
        check_vec("rst_map", 32'(map_idx), 0);
        @(negedge clk_13);
        rst_n = 1'b1;
        tick();

        // First query after reset: requester 0, ROAD0 on map 0
        query("s1_road0", 0, 3, 4, MAP_ROAD0);

        // Move the round-robin pointer to requester 4 so the sweep starts at 0
        query("pre_rr", 4, 3, 8, MAP_ROAD0);

        // All requesters active: 0,1,2,3,4 one every 3 cycles
        for (int k = 0; k < NR; k++) set_rc(k, 3, 4 + k);
        req_valid = '1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n % 3 == 2) begin
                check_vec($sformatf("rr_valid_%0d", n), 32'(resp_valid), 32'(1) << ((n - 2) / 3));
                check_vec($sformatf("rr_type_%0d", n), 32'(resp_type),
                          (((n - 2) / 3) % 2 == 1) ? 32'(MAP_ROAD1) : 32'(MAP_ROAD0));
            end else begin
                check_vec($sformatf("rr_quiet_%0d", n), 32'(resp_valid), 0);
            end
        end
        req_valid = '0;
        tick();
        check_vec("rr_end_busy", 32'(busy), 0);

        // Drop after grant still answers; a request raised and dropped while busy is skipped
        set_rc(2, 3, 6);
        set_rc(3, 3, 7);
        req_valid = 5'b00100;
        tick();
        req_valid = 5'b01000;
        tick();
        check_vec("drop_valid", 32'(resp_valid), 32'b00100);
        check_vec("drop_type", 32'(resp_type), 32'(MAP_ROAD0));
        req_valid = '0;
        tick();
        check_vec("drop_idle_valid", 32'(resp_valid), 0);
        tick();
        check_vec("drop_skip_busy", 32'(busy), 0);

        // Level advance during READ (and again in RESP) completes on old map, one increment
        set_rc(1, 0, 0);
        req_valid = 5'b00010;
        tick();
        level_advance = 1'b1;
        tick();
        check_vec("adv_valid", 32'(resp_valid), 32'b00010);
        check_vec("adv_type", 32'(resp_type), 32'(MAP_WALL));
        check_vec("adv_map_old", 32'(map_idx), 0);
        req_valid = '0;
        tick();
        level_advance = 1'b0;
        check_vec("adv_map_new", 32'(map_idx), 1);
        check_vec("adv_busy", 32'(busy), 0);

        // Pointer reset by the advance: requester 0 beats 2; map 1 data
        set_rc(0, 3, 4);
        set_rc(2, 3, 6);
        req_valid = 5'b00101;
        tick();
        tick();
        check_vec("adv_rr_valid", 32'(resp_valid), 32'b00001);
        check_vec("adv_map1_type", 32'(resp_type), 32'(MAP_ROAD1));
        req_valid = '0;
        tick();

        // Reset during RESP with a pending advance
        set_rc(0, 3, 4);
        req_valid = 5'b00001;
        tick();
        level_advance = 1'b1;
        tick();
        level_advance = 1'b0;
        check_vec("rstx_pre_valid", 32'(resp_valid), 32'b00001);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rstx_valid", 32'(resp_valid), 0);
        check_vec("rstx_type", 32'(resp_type), 32'(MAP_WALL));
        check_vec("rstx_map", 32'(map_idx), 0);
        check_vec("rstx_busy", 32'(busy), 0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check_vec($sformatf("rstx_after_valid_%0d", n), 32'(resp_valid), 0);
            check_vec($sformatf("rstx_after_map_%0d", n), 32'(map_idx), 0);
        end

`ifdef MAP_OOB_CHECK_EN
        query("oob_row", 0, 15, 0, MAP_WALL);
        query("oob_col", 0, 0, 20, MAP_WALL);
        query("oob_alias", 0, 16, 2, MAP_WALL);
`endif

        // Four advances in IDLE saturate at the last map
        for (int i = 0; i < 4; i++) begin
            level_advance = 1'b1;
            tick();
            level_advance = 1'b0;
            check_vec($sformatf("sat_map_%0d", i), 32'(map_idx), (i < 3) ? i + 1 : 3);
        end

        // Map 3 contents
        query("m3_stairs", 0, 13, 18, MAP_STAIRS);
        query("m3_midwall", 0, 5, 10, MAP_WALL);
        query("m3_road1", 0, 3, 4, MAP_ROAD1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
